// File: rtl/header_frame_streamer_pkg.sv
// -----------------------------------------------------------------------------
// header_frame_streamer_pkg
// Shared definitions for the header/payload frame streamer:
//   - DATA_W          : width of header, payload and FIFO words
//   - HDR_IDX_*       : meaning of each header RAM word index
//   - state_t         : framing FSM state encoding
// Optional build macro: TRAILER_CHECKSUM_EN (adds the ST_TRAILER state).
// -----------------------------------------------------------------------------
package header_frame_streamer_pkg;

  localparam int DATA_W = 32;

  // Header RAM word map. Words 1 and 2 are expected to be fed live from the
  // frame_count / pps_count outputs by whoever owns the header RAM.
  localparam int HDR_IDX_RSVD0       = 0;
  localparam int HDR_IDX_FRAME_COUNT = 1;
  localparam int HDR_IDX_PPS_COUNT   = 2;
  localparam int HDR_IDX_RSVD3       = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_RD  = 3'd1,
    ST_HDR_WR  = 3'd2,
    ST_PAYLOAD = 3'd3
`ifdef TRAILER_CHECKSUM_EN
    ,
    ST_TRAILER = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/header_frame_streamer_pps_edge_sync.sv
// -----------------------------------------------------------------------------
// pps_edge_sync
// Brings the asynchronous PPS pulse into the rd_clk domain through a two-flop
// synchronizer and produces a single-cycle pulse on each synchronized rising
// edge.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_pps   : asynchronous PPS input
//   o_rise  : one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module pps_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pps,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // r_sync1/r_sync2 are the metastability chain; r_prev remembers the last
  // synchronized level so a level held for many cycles counts only once.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_pps;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/header_frame_streamer.sv
// -----------------------------------------------------------------------------
// header_frame_streamer
// On each accepted frame_start, reads HDR_WORDS words from an external header
// RAM and writes them to a downstream FIFO, then forwards FRAME_LEN payload
// words from a valid/ready input. Optionally appends an XOR checksum word.
// Parameters:
//   HDR_WORDS : header words per frame (1..16)
//   FRAME_LEN : payload words per frame (1..65535)
// Ports:
//   rd_clk, rst_n              : clock, synchronous active-low reset
//   frame_start                : one-cycle frame request
//   pps_in                     : asynchronous PPS pulse
//   hdr_addr, hdr_rd_en        : header RAM read port (data one cycle later)
//   hdr_data                   : header RAM read data
//   frame_count, pps_count     : live counters for header words 1 and 2
//   din, din_valid, din_ready  : payload input handshake
//   fifo_din, fifo_wr_en       : FIFO write port
//   fifo_full                  : FIFO full flag (no writes while high)
//   busy                       : high whenever not idle
//   overrun                    : sticky, set when frame_start arrives while busy
// Build macro: TRAILER_CHECKSUM_EN adds a trailing XOR checksum word.
// -----------------------------------------------------------------------------
module header_frame_streamer
  import header_frame_streamer_pkg::*;
#(
  parameter int HDR_WORDS = 4,
  parameter int FRAME_LEN = 256
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pps_in,
  output logic [3:0]        hdr_addr,
  output logic              hdr_rd_en,
  input  logic [DATA_W-1:0] hdr_data,
  output logic [DATA_W-1:0] frame_count,
  output logic [DATA_W-1:0] pps_count,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic              busy,
  output logic              overrun
);

  localparam logic [3:0]  HDR_LAST = 4'(HDR_WORDS - 1);
  localparam logic [15:0] PAY_LAST = 16'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_hdr_idx;
  logic [15:0]       r_pay_cnt;
  logic [DATA_W-1:0] r_frame_count;
  logic [DATA_W-1:0] r_pps_count;
  logic              r_overrun;
  logic              r_rd_d1;
  logic [DATA_W-1:0] r_hdr_hold;
  logic [DATA_W-1:0] w_hdr_word;
  logic              w_hdr_rd_en;
  logic [3:0]        w_hdr_addr;
  logic              w_fifo_wr_en;
  logic [DATA_W-1:0] w_fifo_din;
  logic              w_din_ready;
  logic              w_busy;
  logic              w_frame_done;
  logic              w_start;
  logic              w_pps_rise;
`ifdef TRAILER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  pps_edge_sync u_pps_edge_sync (
    .i_clk   (rd_clk),
    .i_rst_n (rst_n),
    .i_pps   (pps_in),
    .o_rise  (w_pps_rise)
  );

  always_ff @(posedge rd_clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // The RAM only guarantees hdr_data in the cycle after the read strobe, so a
  // stalled HDR_WR falls back to the copy captured in r_hdr_hold.
  always_comb begin
    w_next_state = r_state;
    w_hdr_rd_en  = 1'b0;
    w_hdr_addr   = '0;
    w_fifo_wr_en = 1'b0;
    w_fifo_din   = '0;
    w_din_ready  = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    w_hdr_word   = r_rd_d1 ? hdr_data : r_hdr_hold;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (frame_start) w_next_state = ST_HDR_RD;
      end
      ST_HDR_RD: begin
        w_hdr_rd_en  = 1'b1;
        w_hdr_addr   = r_hdr_idx;
        w_next_state = ST_HDR_WR;
      end
      ST_HDR_WR: begin
        w_fifo_din = w_hdr_word;
        if (!fifo_full) begin
          w_fifo_wr_en = 1'b1;
          w_next_state = (r_hdr_idx == HDR_LAST) ? ST_PAYLOAD : ST_HDR_RD;
        end
      end
      ST_PAYLOAD: begin
        w_din_ready = !fifo_full;
        if (din_valid && !fifo_full) begin
          w_fifo_wr_en = 1'b1;
          w_fifo_din   = din;
          if (r_pay_cnt == PAY_LAST) begin
            w_frame_done = 1'b1;
`ifdef TRAILER_CHECKSUM_EN
            w_next_state = ST_TRAILER;
`else
            w_next_state = ST_IDLE;
`endif
          end
        end
      end
`ifdef TRAILER_CHECKSUM_EN
      ST_TRAILER: begin
        w_fifo_din = r_csum;
        if (!fifo_full) begin
          w_fifo_wr_en = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_start = (r_state == ST_IDLE) && frame_start;

  // Frame counters, header index and status. frame_count moves only on the
  // last payload accept so header reads always see a stable value.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      r_hdr_idx     <= '0;
      r_pay_cnt     <= '0;
      r_rd_d1       <= 1'b0;
      r_hdr_hold    <= '0;
      r_frame_count <= '0;
      r_pps_count   <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_rd_d1 <= w_hdr_rd_en;
      if (r_state == ST_HDR_WR) r_hdr_hold <= w_hdr_word;
      if (w_start) begin
        r_hdr_idx <= '0;
        r_pay_cnt <= '0;
      end
      if ((r_state == ST_HDR_WR) && w_fifo_wr_en && (r_hdr_idx != HDR_LAST))
        r_hdr_idx <= r_hdr_idx + 4'd1;
      if ((r_state == ST_PAYLOAD) && w_fifo_wr_en)
        r_pay_cnt <= w_frame_done ? 16'd0 : r_pay_cnt + 16'd1;
      if (w_frame_done) r_frame_count <= r_frame_count + 32'd1;
      if (w_pps_rise)   r_pps_count   <= r_pps_count + 32'd1;
      if (frame_start && w_busy) r_overrun <= 1'b1;
    end
  end

`ifdef TRAILER_CHECKSUM_EN
  // Running XOR of every header and payload word written in this frame.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_fifo_wr_en && ((r_state == ST_HDR_WR) || (r_state == ST_PAYLOAD))) begin
      r_csum <= r_csum ^ w_fifo_din;
    end
  end
`endif

  assign hdr_addr    = w_hdr_addr;
  assign hdr_rd_en   = w_hdr_rd_en;
  assign fifo_wr_en  = w_fifo_wr_en;
  assign fifo_din    = w_fifo_din;
  assign din_ready   = w_din_ready;
  assign busy        = w_busy;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;
  assign pps_count   = r_pps_count;

endmodule

// File: tb/tb_header_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_header_frame_streamer
// Scoreboard bench for header_frame_streamer (HDR_WORDS=4, FRAME_LEN=8).
// Each frame request pushes its expected FIFO words into expQ; an independent
// monitor pops and compares on every FIFO write.
// -----------------------------------------------------------------------------
module tb_header_frame_streamer;
  import header_frame_streamer_pkg::*;

  localparam int HDR_WORDS = 4;
  localparam int FRAME_LEN = 8;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pps_in = 1'b0;
  logic [3:0]  hdr_addr;
  logic        hdr_rd_en;
  logic [31:0] hdr_data = '0;
  logic [31:0] frame_count;
  logic [31:0] pps_count;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int writesSeen = 0;
  logic [31:0] expQ[$];
  logic [31:0] ram [16];
  logic [31:0] modelFc = 0;
  logic [31:0] modelPps = 0;

  header_frame_streamer #(.HDR_WORDS(HDR_WORDS), .FRAME_LEN(FRAME_LEN)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .frame_start(frame_start), .pps_in(pps_in),
    .hdr_addr(hdr_addr), .hdr_rd_en(hdr_rd_en), .hdr_data(hdr_data),
    .frame_count(frame_count), .pps_count(pps_count),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .busy(busy), .overrun(overrun)
  );

  always #5 rd_clk = ~rd_clk;

  // Header RAM with one-cycle read latency; words 1 and 2 come from the live
  // counters exactly as the system integration wires them.
  always @(posedge rd_clk) begin
    if (hdr_rd_en) begin
      if (hdr_addr == 4'(HDR_IDX_FRAME_COUNT))    hdr_data <= frame_count;
      else if (hdr_addr == 4'(HDR_IDX_PPS_COUNT)) hdr_data <= pps_count;
      else                                        hdr_data <= ram[hdr_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: every FIFO write must match the next expected word and must
  // never happen while the FIFO reports full.
  always @(negedge rd_clk) begin
    if (fifo_wr_en) begin
      writesSeen++;
      checkOutput("wr_while_full", {31'b0, fifo_full}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got=%h expected=no write", fifo_din);
      end else begin
        checkOutput("fifo_word", fifo_din, expQ.pop_front());
      end
    end
  end

  function automatic logic [31:0] hdrExpect(input int i);
    if (i == HDR_IDX_FRAME_COUNT) return modelFc;
    if (i == HDR_IDX_PPS_COUNT)   return modelPps;
    return ram[i];
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    fifo_full = 1'b1;
    din_valid = 1'b0;
    frame_start = 1'b0;
    pps_in = 1'b0;
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    checkOutput("rst_hdr_addr", {28'b0, hdr_addr}, 32'd0);
    checkOutput("rst_hdr_rd_en", {31'b0, hdr_rd_en}, 32'd0);
    checkOutput("rst_fifo_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    checkOutput("rst_fifo_din", fifo_din, 32'd0);
    checkOutput("rst_din_ready", {31'b0, din_ready}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_overrun", {31'b0, overrun}, 32'd0);
    checkOutput("rst_frame_count", frame_count, 32'd0);
    checkOutput("rst_pps_count", pps_count, 32'd0);
    expQ.delete();
    modelFc = 0;
    modelPps = 0;
    @(posedge rd_clk);
    #1;
    rst_n = 1'b1;
    fifo_full = 1'b0;
  endtask

  task automatic ppsPulses(input int n);
    for (int p = 0; p < n; p++) begin
      @(posedge rd_clk); #3; pps_in = 1'b1;
      repeat (2) @(posedge rd_clk); #3; pps_in = 1'b0;
      repeat (3) @(posedge rd_clk);
    end
    modelPps = modelPps + 32'(n);
    repeat (4) @(posedge rd_clk);
    @(negedge rd_clk);
    checkOutput("pps_count", pps_count, modelPps);
  endtask

  // One frame: expected words are queued up front from the header map and
  // the generated payload; then the payload is offered under random or
  // scripted backpressure. abortAt>=0 leaves the frame mid-payload.
  task automatic applyStimulus(input bit directed, input bit midStart, input int fullPct,
                               input int validPct, input bit countUp, input int abortAt);
    logic [31:0] pay [FRAME_LEN];
    logic [31:0] cs;
    logic [31:0] w;
    int idx, budget, stallLeft, startW;
    bit stA, stB, midDone;
    cs = '0;
    for (int i = 0; i < FRAME_LEN; i++) pay[i] = countUp ? 32'(i + 1) : $urandom;
    for (int i = 0; i < HDR_WORDS; i++) begin
      w = hdrExpect(i);
      expQ.push_back(w);
      cs = cs ^ w;
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      expQ.push_back(pay[i]);
      cs = cs ^ pay[i];
    end
`ifdef TRAILER_CHECKSUM_EN
    expQ.push_back(cs);
`endif
    modelFc = modelFc + 32'd1;
    startW = writesSeen;
    @(posedge rd_clk); #1; frame_start = 1'b1;
    @(posedge rd_clk); #1; frame_start = 1'b0;
    idx = 0; budget = 0; stallLeft = 0; stA = 0; stB = 0; midDone = 0;
    while (!(idx == FRAME_LEN && !busy) && budget < 2000) begin
      if (abortAt >= 0 && idx == abortAt) break;
      if (directed && !stA && (writesSeen - startW) == 2) begin stA = 1; stallLeft = 5; end
      if (directed && !stB && idx == 3) begin stB = 1; stallLeft = 5; end
      if (stallLeft > 0) begin
        fifo_full = 1'b1;
        stallLeft--;
      end else begin
        fifo_full = (($urandom % 100) < 32'(fullPct));
      end
      din = (idx < FRAME_LEN) ? pay[idx] : $urandom;
      din_valid = (idx < FRAME_LEN) && (($urandom % 100) < 32'(validPct));
      frame_start = midStart && !midDone && idx == 4;
      if (frame_start) midDone = 1;
      @(negedge rd_clk);
      if (din_valid && din_ready) idx++;
      @(posedge rd_clk); #1;
      frame_start = 1'b0;
      budget++;
    end
    if (abortAt < 0) begin
      if (budget >= 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL frame_timeout: got=%0d accepted expected=%0d", idx, FRAME_LEN);
      end
      din_valid = 1'b0;
      fifo_full = 1'b0;
      repeat (3) @(posedge rd_clk);
      @(negedge rd_clk);
      checkOutput("frame_count", frame_count, modelFc);
      checkOutput("busy_after_frame", {31'b0, busy}, 32'd0);
      checkOutput("din_ready_idle", {31'b0, din_ready}, 32'd0);
      checkOutput("words_missing", 32'(expQ.size()), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: got=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = $urandom;
    doReset();

    // Directed single frame with counting payload.
    ram[HDR_IDX_RSVD0] = 32'hA;
    ram[HDR_IDX_RSVD3] = 32'hD;
    applyStimulus(1'b0, 1'b0, 0, 100, 1'b1, -1);
    checkOutput("overrun_clean", {31'b0, overrun}, 32'd0);

    // Scripted 5-cycle full bursts in header and payload.
    applyStimulus(1'b1, 1'b0, 0, 100, 1'b1, -1);

    // PPS pulses then a frame that reports them.
    ppsPulses(3);
    applyStimulus(1'b0, 1'b0, 0, 100, 1'b0, -1);

    // Mid-frame request must be dropped and flagged.
    applyStimulus(1'b0, 1'b1, 0, 100, 1'b0, -1);
    checkOutput("overrun_set", {31'b0, overrun}, 32'd1);
    repeat (30) @(posedge rd_clk);
    @(negedge rd_clk);
    checkOutput("single_frame_busy", {31'b0, busy}, 32'd0);

    // Random frames with random backpressure and PPS activity.
    for (int f = 0; f < 6; f++) begin
      ram[HDR_IDX_RSVD0] = $urandom;
      ram[HDR_IDX_RSVD3] = $urandom;
      if (f % 2 == 1) ppsPulses(int'($urandom_range(1, 3)));
      applyStimulus(1'b0, 1'b0, 25, 75, 1'b0, -1);
    end

    // Reset in the middle of a payload: nothing more may reach the FIFO.
    applyStimulus(1'b0, 1'b0, 0, 100, 1'b0, 3);
    doReset();
    din_valid = 1'b1;
    repeat (20) @(posedge rd_clk);
    @(negedge rd_clk);
    checkOutput("abort_frame_count", frame_count, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    din_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 10, 90, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/header_frame_streamer.md
HEADER_FRAME_STREAMER -- requirements
Module: header_frame_streamer

Interface
REQ-001 The block SHALL have parameter HDR_WORDS, default 4, meaning the number of header RAM words emitted per frame (1..16).
REQ-002 The block SHALL have parameter FRAME_LEN, default 256, meaning the number of payload words per frame (1..65535).
REQ-003 The block SHALL have port rd_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-005 The block SHALL have port frame_start, input, 1 bit: one-cycle request to emit one frame.
REQ-006 The block SHALL have port pps_in, input, 1 bit: asynchronous PPS pulse.
REQ-007 The block SHALL have port hdr_addr, output, 4 bits: header RAM word address.
REQ-008 The block SHALL have port hdr_rd_en, output, 1 bit: header RAM read strobe.
REQ-009 The block SHALL have port hdr_data, input, 32 bits: header RAM word, valid one cycle after hdr_rd_en.
REQ-010 The block SHALL have port frame_count, output, 32 bits: completed-frame counter, fed to header RAM word 1.
REQ-011 The block SHALL have port pps_count, output, 32 bits: PPS edge counter, fed to header RAM word 2.
REQ-012 The block SHALL have port din, input, 32 bits: payload sample.
REQ-013 The block SHALL have port din_valid, input, 1 bit: payload sample valid.
REQ-014 The block SHALL have port din_ready, output, 1 bit: payload sample accepted when din_valid and din_ready are both high.
REQ-015 The block SHALL have port fifo_din, output, 32 bits: word to the downstream FIFO.
REQ-016 The block SHALL have port fifo_wr_en, output, 1 bit: FIFO write strobe.
REQ-017 The block SHALL have port fifo_full, input, 1 bit: FIFO full flag.
REQ-018 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-019 The block SHALL have port overrun, output, 1 bit: sticky flag set when frame_start is dropped.

Function
REQ-020 The FSM SHALL have states IDLE, HDR_RD, HDR_WR, PAYLOAD and TRAILER (TRAILER only when configured).
- IDLE: frame_start moves to HDR_RD with k=0.
- HDR_RD: drive hdr_addr=k and hdr_rd_en=1 for one cycle, then go to HDR_WR.
- HDR_WR: hold until !fifo_full, then write the registered hdr_data. If k==HDR_WORDS-1, go to PAYLOAD; else k++ and return to HDR_RD.
REQ-021 In PAYLOAD, din_ready SHALL equal !fifo_full, and each accepted din SHALL produce fifo_wr_en=1 with fifo_din=din in the same cycle.
REQ-022 After FRAME_LEN accepted words, the FSM SHALL increment frame_count by 1 and go to IDLE, or to TRAILER if configured.
REQ-023 fifo_wr_en SHALL never be asserted while fifo_full=1.
REQ-024 frame_count and pps_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 frame_count SHALL change only at frame end, so it is stable during header reads.
REQ-026 pps_in SHALL pass through a 2-flop synchronizer, and pps_count SHALL increment once per synchronized rising edge, in any state.
REQ-027 frame_start while busy=1 SHALL be ignored and SHALL set overrun; frame_start on the frame-end cycle is also ignored.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 din_ready SHALL be 0 outside PAYLOAD.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL return to IDLE and clear to 0: k, the payload counter, frame_count, pps_count, the synchronizer, overrun, hdr_rd_en, hdr_addr, fifo_wr_en, fifo_din, din_ready and busy.
REQ-031 Reset mid-frame SHALL abandon the frame with no further FIFO writes and no frame_count increment.

Configuration
REQ-032 With TRAILER_CHECKSUM_EN defined, TRAILER SHALL hold until !fifo_full, then write one word equal to the XOR of all header and payload words of the frame, then go to IDLE.
REQ-033 Without TRAILER_CHECKSUM_EN, there SHALL be no TRAILER state, no checksum register, and the frame length SHALL be HDR_WORDS+FRAME_LEN words.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, data width 32 and the header word indices (0 reserved, 1 frame_count, 2 pps_count, 3 reserved).
REQ-035 The PPS synchronizer and edge detector SHALL be one sub-module, pps_edge_sync.

Verification
REQ-036 Reset test: rst_n low for 3 cycles -> all outputs 0, busy=0, frame_count=0.
REQ-037 Single frame test: HDR_WORDS=4, FRAME_LEN=8, RAM {0xA, fc, pps, 0xD}, din 1..8 always valid, fifo_full=0 -> exactly 12 writes in order 0xA, 0, 0, 0xD, 1..8, and frame_count=1 afterwards.
REQ-038 Backpressure test: fifo_full held high for 5 cycles during header word 2 and during payload word 4 -> no writes while full, no word lost or duplicated, order unchanged.
REQ-039 Overrun test: frame_start pulsed in the middle of a frame -> overrun=1 and only one frame emitted.
REQ-040 PPS test: 3 pps_in pulses -> pps_count=3; a following frame carries header word 2 = 3.
REQ-041 Checksum test (TRAILER_CHECKSUM_EN): frame as in REQ-037 -> a 13th word equal to 0xA^0^0^0xD^1^2^...^8 = 0x0F.
